// File: rtl/acum_pkg.sv
// Shared definitions for the accumulator result path.
package acum_pkg;

    localparam int unsigned ACUM_DATA_W  = 6;
    localparam int unsigned ACUM_ENTRY_W = ACUM_DATA_W + 1;

    // FIFO entry layout: overflow flag above the data bits.
    function automatic logic [ACUM_ENTRY_W-1:0] pack_entry(
        input logic                   ovf,
        input logic [ACUM_DATA_W-1:0] data
    );
        return {ovf, data};
    endfunction

    // Largest value a w-bit saturating counter may hold.
    function automatic logic [31:0] SAT_MAX(input int unsigned w);
        return (w >= 32) ? '1 : ((32'd1 << w) - 32'd1);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: counts i_inc pulses and holds at its maximum.
module sat_counter
    import acum_pkg::*;
#(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         i_rst,
    input  logic         i_inc,
    output logic [W-1:0] o_cnt
);

    localparam logic [W-1:0] CNT_MAX = W'(SAT_MAX(W));

    // Count up on i_inc, stop at CNT_MAX, clear on reset.
    always_ff @(posedge clk) begin
        if (i_rst) begin
            o_cnt <= '0;
        end else if (i_inc && (o_cnt != CNT_MAX)) begin
            o_cnt <= o_cnt + W'(1);
        end
    end

endmodule

// File: rtl/acum_result_fifo.sv
// First-word-fall-through FIFO for accumulator results, with drop and
// overflow-edge statistics.
module acum_result_fifo
    import acum_pkg::*;
#(
    parameter int unsigned DATA_W = ACUM_DATA_W,
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned CNT_W  = 8
) (
    input  logic                     clk,
    input  logic                     i_rst,
    input  logic [DATA_W-1:0]        i_data,
    input  logic                     i_overflow,
    input  logic                     i_valid,
    input  logic                     i_ready,
    output logic [DATA_W:0]          o_data,
    output logic                     o_valid,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_level,
    output logic [CNT_W-1:0]         o_drop_cnt,
    output logic [CNT_W-1:0]         o_ovf_cnt
);

    localparam int unsigned PTR_W   = $clog2(DEPTH);
    localparam int unsigned LVL_W   = PTR_W + 1;
    localparam int unsigned ENTRY_W = DATA_W + 1;

    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   wr_ptr;
    logic [LVL_W-1:0]   level;
    logic               prev_ovf;

    logic pop;
    logic push;
    logic drop;
    logic ovf_edge;

    // Handshake decode; a full FIFO still accepts a write when it pops.
    always_comb begin
        pop      = o_valid & i_ready;
        push     = i_valid & (~o_full | pop);
        drop     = i_valid & o_full & ~pop;
        ovf_edge = i_valid & i_overflow & ~prev_ovf;
    end

    // Status and head entry, all straight from registers.
    always_comb begin
        o_full  = (level == LVL_W'(DEPTH));
        o_empty = (level == '0);
        o_valid = ~o_empty;
        o_level = level;
        o_data  = mem[rd_ptr];
    end

    // Storage write; held off during reset so a discarded result never lands.
    always_ff @(posedge clk) begin
        if (push && !i_rst) begin
            mem[wr_ptr] <= {i_overflow, i_data};
        end
    end

    // Pointers, occupancy and the last-sampled overflow flag.
    always_ff @(posedge clk) begin
        if (i_rst) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            level    <= '0;
            prev_ovf <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
            if (i_valid) prev_ovf <= i_overflow;
        end
    end

    sat_counter #(.W(CNT_W)) u_drop_cnt (
        .clk   (clk),
        .i_rst (i_rst),
        .i_inc (drop),
        .o_cnt (o_drop_cnt)
    );

    sat_counter #(.W(CNT_W)) u_ovf_cnt (
        .clk   (clk),
        .i_rst (i_rst),
        .i_inc (ovf_edge),
        .o_cnt (o_ovf_cnt)
    );

endmodule

// File: tb/tb_acum_result_fifo.sv
// Scoreboard bench for acum_result_fifo; a second instance with 2-bit
// counters shares the stimulus to exercise saturation.
module tb_acum_result_fifo;
    import acum_pkg::*;

    localparam int unsigned DEPTH = 4;

    logic       clk = 1'b0;
    logic       i_rst = 1'b0;
    logic [5:0] i_data = '0;
    logic       i_overflow = 1'b0;
    logic       i_valid = 1'b0;
    logic       i_ready = 1'b0;

    logic [6:0] o_data;
    logic       o_valid, o_full, o_empty;
    logic [2:0] o_level;
    logic [7:0] o_drop_cnt, o_ovf_cnt;

    logic [6:0] o_data2;
    logic       o_valid2, o_full2, o_empty2;
    logic [2:0] o_level2;
    logic [1:0] o_drop_cnt2, o_ovf_cnt2;

    int tests_run = 0;
    int tests_failed = 0;

    logic [6:0] sb_q[$];

    always #5 clk = ~clk;

    acum_result_fifo #(.DATA_W(6), .DEPTH(DEPTH), .CNT_W(8)) dut (
        .clk(clk), .i_rst(i_rst), .i_data(i_data), .i_overflow(i_overflow),
        .i_valid(i_valid), .i_ready(i_ready), .o_data(o_data), .o_valid(o_valid),
        .o_full(o_full), .o_empty(o_empty), .o_level(o_level),
        .o_drop_cnt(o_drop_cnt), .o_ovf_cnt(o_ovf_cnt)
    );

    acum_result_fifo #(.DATA_W(6), .DEPTH(DEPTH), .CNT_W(2)) dut_sat (
        .clk(clk), .i_rst(i_rst), .i_data(i_data), .i_overflow(i_overflow),
        .i_valid(i_valid), .i_ready(i_ready), .o_data(o_data2), .o_valid(o_valid2),
        .o_full(o_full2), .o_empty(o_empty2), .o_level(o_level2),
        .o_drop_cnt(o_drop_cnt2), .o_ovf_cnt(o_ovf_cnt2)
    );

    // One clock of stimulus; pops are scored against the queue before the edge.
    task automatic step(input logic rst, input logic v, input logic [5:0] d,
                        input logic ovf, input logic rdy);
        logic       pop, push, full;
        logic [6:0] exp;
        i_rst = rst; i_valid = v; i_data = d; i_overflow = ovf; i_ready = rdy;
        full = (sb_q.size() == DEPTH);
        pop  = rdy && (sb_q.size() != 0) && !rst;
        push = v && (!full || pop) && !rst;
        if (pop) begin
            exp = sb_q.pop_front();
            tests_run++;
            if (o_data !== exp) begin
                tests_failed++;
                $display("FAIL pop_data: got %h expected %h", o_data, exp);
            end
        end
        if (push) sb_q.push_back(pack_entry(ovf, d));
        if (rst) sb_q.delete();
        @(posedge clk);
        #1;
        i_rst = 1'b0; i_valid = 1'b0; i_ready = 1'b0;
    endtask

    task automatic test_reset();
        step(1'b1, 1'b0, 6'd0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            tests_run++;
            if (o_valid !== 1'b0 || o_empty !== 1'b1 || o_full !== 1'b0 ||
                o_level !== 3'd0 || o_drop_cnt !== 8'd0 || o_ovf_cnt !== 8'd0) begin
                tests_failed++;
                $display("FAIL reset_idle[%0d]: valid=%b empty=%b full=%b level=%0d drop=%0d ovf=%0d expected 0 1 0 0 0 0",
                         i, o_valid, o_empty, o_full, o_level, o_drop_cnt, o_ovf_cnt);
            end
            step(1'b0, 1'b0, 6'd0, 1'b0, 1'b0);
        end
    endtask

    task automatic test_fill();
        logic [5:0] dv [4];
        logic       ov [4];
        dv = '{6'd3, 6'd7, 6'd12, 6'd63};
        ov = '{1'b0, 1'b0, 1'b1, 1'b1};
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b1, dv[i], ov[i], 1'b0);
            tests_run++;
            if (o_level !== 3'(i + 1)) begin
                tests_failed++;
                $display("FAIL fill_level[%0d]: got %0d expected %0d", i, o_level, i + 1);
            end
        end
        tests_run++;
        if (o_full !== 1'b1 || o_data !== 7'h03) begin
            tests_failed++;
            $display("FAIL fill_full: full=%b data=%h expected 1 03", o_full, o_data);
        end
        step(1'b0, 1'b1, 6'd5, 1'b0, 1'b0);
        tests_run++;
        if (o_drop_cnt !== 8'd1 || o_level !== 3'd4 || o_data !== 7'h03) begin
            tests_failed++;
            $display("FAIL fill_drop: drop=%0d level=%0d data=%h expected 1 4 03",
                     o_drop_cnt, o_level, o_data);
        end
        tests_run++;
        if (o_ovf_cnt !== 8'd1) begin
            tests_failed++;
            $display("FAIL fill_ovf: got %0d expected 1", o_ovf_cnt);
        end
    endtask

    task automatic test_drain();
        logic [6:0] ev [4];
        ev = '{7'h03, 7'h07, 7'h4C, 7'h7F};
        for (int i = 0; i < 4; i++) begin
            tests_run++;
            if (o_valid !== 1'b1 || o_data !== ev[i]) begin
                tests_failed++;
                $display("FAIL drain_head[%0d]: valid=%b data=%h expected 1 %h", i, o_valid, o_data, ev[i]);
            end
            step(1'b0, 1'b0, 6'd0, 1'b0, 1'b1);
        end
        tests_run++;
        if (o_valid !== 1'b0 || o_empty !== 1'b1 || o_level !== 3'd0) begin
            tests_failed++;
            $display("FAIL drain_empty: valid=%b empty=%b level=%0d expected 0 1 0", o_valid, o_empty, o_level);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 6'(10 + i), 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b1, 6'(i + 1), 1'b0, 1'b1);
            tests_run++;
            if (o_level !== 3'd4 || o_full !== 1'b1 || o_drop_cnt !== 8'd1) begin
                tests_failed++;
                $display("FAIL b2b[%0d]: level=%0d full=%b drop=%0d expected 4 1 1", i, o_level, o_full, o_drop_cnt);
            end
        end
        for (int i = 0; i < 4; i++) begin
            tests_run++;
            if (o_data !== 7'(i + 1)) begin
                tests_failed++;
                $display("FAIL b2b_order[%0d]: got %h expected %h", i, o_data, 7'(i + 1));
            end
            step(1'b0, 1'b0, 6'd0, 1'b0, 1'b1);
        end
        tests_run++;
        if (o_empty !== 1'b1) begin
            tests_failed++;
            $display("FAIL b2b_empty: got %b expected 1", o_empty);
        end
    endtask

    task automatic test_ovf_edges();
        logic pat [5];
        pat = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        step(1'b1, 1'b0, 6'd0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 6'(i), pat[i], 1'b1);
        tests_run++;
        if (o_ovf_cnt !== 8'd2) begin
            tests_failed++;
            $display("FAIL ovf_edges: got %0d expected 2", o_ovf_cnt);
        end
        step(1'b0, 1'b0, 6'd0, 1'b0, 1'b1);
        step(1'b0, 1'b1, 6'd9, 1'b1, 1'b1);
        tests_run++;
        if (o_ovf_cnt !== 8'd2) begin
            tests_failed++;
            $display("FAIL ovf_hold_high: got %0d expected 2", o_ovf_cnt);
        end
        step(1'b0, 1'b0, 6'd0, 1'b0, 1'b1);
    endtask

    task automatic test_drop_sat();
        logic [1:0] exp2;
        step(1'b1, 1'b0, 6'd0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 6'd20, 1'b0, 1'b0);
        step(1'b0, 1'b1, 6'd21, 1'b1, 1'b0);
        step(1'b0, 1'b1, 6'd22, 1'b0, 1'b0);
        step(1'b0, 1'b1, 6'd23, 1'b1, 1'b0);
        for (int k = 1; k <= 5; k++) begin
            step(1'b0, 1'b1, 6'd40, 1'b0, 1'b0);
            exp2 = (k < 3) ? 2'(k) : 2'd3;
            tests_run++;
            if (o_drop_cnt2 !== exp2 || o_drop_cnt !== 8'(k)) begin
                tests_failed++;
                $display("FAIL drop_sat[%0d]: cnt2=%0d cnt8=%0d expected %0d %0d", k, o_drop_cnt2, o_drop_cnt, exp2, k);
            end
        end
        tests_run++;
        if (o_level2 !== 3'd4 || o_full2 !== 1'b1 || o_empty2 !== 1'b0 ||
            o_valid2 !== 1'b1 || o_data2 !== 7'h14 || o_ovf_cnt2 !== 2'd2) begin
            tests_failed++;
            $display("FAIL sat_inst: level=%0d full=%b empty=%b valid=%b data=%h ovf=%0d expected 4 1 0 1 14 2",
                     o_level2, o_full2, o_empty2, o_valid2, o_data2, o_ovf_cnt2);
        end
    endtask

    task automatic test_reset_mid();
        step(1'b1, 1'b0, 6'd0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 6'd1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 6'd2, 1'b1, 1'b0);
        step(1'b0, 1'b1, 6'd3, 1'b1, 1'b0);
        tests_run++;
        if (o_level !== 3'd3 || o_ovf_cnt !== 8'd1) begin
            tests_failed++;
            $display("FAIL mid_pre: level=%0d ovf=%0d expected 3 1", o_level, o_ovf_cnt);
        end
        step(1'b1, 1'b1, 6'd33, 1'b1, 1'b1);
        tests_run++;
        if (o_level !== 3'd0 || o_valid !== 1'b0 || o_empty !== 1'b1 ||
            o_drop_cnt !== 8'd0 || o_ovf_cnt !== 8'd0) begin
            tests_failed++;
            $display("FAIL mid_reset: level=%0d valid=%b empty=%b drop=%0d ovf=%0d expected 0 0 1 0 0",
                     o_level, o_valid, o_empty, o_drop_cnt, o_ovf_cnt);
        end
        step(1'b0, 1'b0, 6'd0, 1'b0, 1'b0);
        tests_run++;
        if (o_level !== 3'd0 || o_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL mid_nowrite: level=%0d valid=%b expected 0 0", o_level, o_valid);
        end
        step(1'b0, 1'b1, 6'd17, 1'b1, 1'b0);
        tests_run++;
        if (o_ovf_cnt !== 8'd1 || o_data !== 7'h51 || o_level !== 3'd1) begin
            tests_failed++;
            $display("FAIL mid_post: ovf=%0d data=%h level=%0d expected 1 51 1", o_ovf_cnt, o_data, o_level);
        end
        step(1'b0, 1'b0, 6'd0, 1'b0, 1'b1);
    endtask

    initial begin
        @(posedge clk);
        #1;
        test_reset();
        test_fill();
        test_drain();
        test_back_to_back();
        test_ovf_edges();
        test_drop_sat();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
